iter_muldiv: RTL and testbench

- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Unlike the combinational ALU, it is multi-cycle: one-bit-per-cycle shift-add / restoring shift-subtract, with a start/busy/done handshake.
- The pipeline stalls on busy; MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/iter_muldiv_if.sv | 25 ++
 rtl/iter_muldiv.sv | 167 ++++++++++++++++
 tb/tb_iter_muldiv.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side (execute stage) issues requests; the slave side is the unit itself.
interface iter_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div0;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div0
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div0
    );
endinterface

// File: rtl/iter_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring shift-subtract divide, then sign fix-up.
module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input logic         clk,
    input logic         rstn,
    iter_muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz;
    logic             mt_pend;
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor magnitude

    logic             signed_op;
    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    // FIN already has the result in hand, so a new request can be taken on the commit edge.
    assign accept    = bus.start && ((state == S_IDLE) || (state == S_FIN));
    // The magnitude of the most negative value is representable as an unsigned W-bit number.
    assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_sh >= {1'b0, opnd};
    assign div_diff  = div_sh[WIDTH-1:0] - opnd;
    assign prod_neg  = -{acc_hi, acc_lo};

    assign bus.busy  = (state == S_RUN) || (state == S_FIX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
            mt_pend  <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.div0 <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all next-state terms see pre-edge values.
            bus.done <= mt_pend;
            mt_pend  <= 1'b0;

            case (state)
                S_RUN: begin
                    if (is_div) begin
                        if (div_ge) begin
                            acc_hi <= div_diff;
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (is_div) begin
                        // A zero divisor leaves the all-ones quotient unsigned.
                        if (neg_lo && !dz) begin
                            acc_lo <= -acc_lo;
                        end
                        if (neg_hi) begin
                            acc_hi <= -acc_hi;
                        end
                    end else if (neg_lo) begin
                        {acc_hi, acc_lo} <= prod_neg;
                    end
                    state <= S_FIN;
                end

                S_FIN: begin
                    bus.hi   <= acc_hi;
                    bus.lo   <= acc_lo;
                    bus.div0 <= dz;
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end

                default: ;
            endcase

            if (accept) begin
                case (bus.op)
                    OP_MULT, OP_MULTU: begin
                        is_div   <= 1'b0;
                        neg_lo   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_hi   <= 1'b0;
                        dz       <= 1'b0;
                        acc_hi   <= '0;
                        acc_lo   <= b_mag;
                        opnd     <= a_mag;
                        cnt      <= CW'(WIDTH);
                        bus.div0 <= 1'b0;
                        state    <= S_RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        is_div   <= 1'b1;
                        neg_lo   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_hi   <= signed_op && bus.a[WIDTH-1];
                        dz       <= (bus.b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                        opnd     <= b_mag;
                        cnt      <= CW'(WIDTH);
                        bus.div0 <= 1'b0;
                        state    <= S_RUN;
                    end
                    OP_MTHI: begin
                        bus.hi   <= bus.a;
                        bus.div0 <= 1'b0;
                        mt_pend  <= 1'b1;
                    end
                    OP_MTLO: begin
                        bus.lo   <= bus.a;
                        bus.div0 <= 1'b0;
                        mt_pend  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: a 32-bit instance for the main sequence
// and an 8-bit instance for the narrow-width case.
module tb_iter_muldiv;
    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    iter_muldiv_if #(.WIDTH(32)) bus32 ();
    iter_muldiv_if #(.WIDTH(8))  bus8 ();

    iter_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rstn(rstn), .bus(bus32));
    iter_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one 32-bit request, then watches outputs at each falling edge.
    // k counts rising edges after the accepting edge; lat is the k at which done is seen.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int repulse_at, input int rst_at,
                         output int lat, output int nbusy, output int ndone,
                         output logic div0_acc);
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        @(posedge clk);
        lat      = -1;
        nbusy    = 0;
        ndone    = 0;
        div0_acc = 1'bx;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus32.start = 1'b0;
                bus32.a     = '0;
                bus32.b     = '0;
                div0_acc    = bus32.div0;
            end
            if (k == repulse_at) begin
                bus32.start = 1'b1;
                bus32.op    = 3'b000;
                bus32.a     = 32'd2;
                bus32.b     = 32'd3;
            end
            if (k == repulse_at + 1) bus32.start = 1'b0;
            if (k == rst_at) begin
                rstn = 1'b0;
                #1;
                check("rst_async_busy", 64'(bus32.busy), 64'd0);
                check("rst_async_done", 64'(bus32.done), 64'd0);
                check("rst_async_hi", 64'(bus32.hi), 64'd0);
                check("rst_async_lo", 64'(bus32.lo), 64'd0);
                check("rst_async_div0", 64'(bus32.div0), 64'd0);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            if (bus32.busy) nbusy++;
            if (bus32.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (lat >= 0 && k >= lat + 6) break;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) bus8.start = 1'b0;
            if (bus8.done) begin
                lat = k;
                break;
            end
        end
    endtask

    int   lat;
    int   nbusy;
    int   ndone;
    int   cnt;
    logic d0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        bus32.start = 1'b0;
        bus32.op    = '0;
        bus32.a     = '0;
        bus32.b     = '0;
        bus8.start  = 1'b0;
        bus8.op     = '0;
        bus8.a      = '0;
        bus8.b      = '0;

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(bus32.busy), 64'd0);
        check("reset_done", 64'(bus32.done), 64'd0);
        check("reset_hi", 64'(bus32.hi), 64'd0);
        check("reset_lo", 64'(bus32.lo), 64'd0);
        check("reset_div0", 64'(bus32.div0), 64'd0);
        check("reset8_hilo", {48'd0, bus8.hi, bus8.lo}, 64'd0);
        rstn = 1'b1;

        // MULTU max x max
        run32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, lat, nbusy, ndone, d0);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_busy_cycles", 64'(nbusy), 64'd33);
        check("multu_done_pulses", 64'(ndone), 64'd1);
        check("multu_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT -3 x 7
        run32(3'b000, 32'hFFFF_FFFD, 32'd7, -1, -1, lat, nbusy, ndone, d0);
        check("mult_neg_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // DIV -7 / 2
        run32(3'b010, 32'hFFFF_FFF9, 32'd2, -1, -1, lat, nbusy, ndone, d0);
        check("div_neg_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_neg_div0", 64'(bus32.div0), 64'd0);

        // DIVU 100 / 0
        run32(3'b011, 32'd100, 32'd0, -1, -1, lat, nbusy, ndone, d0);
        check("divu0_lat", 64'(lat), 64'd34);
        check("divu0_hilo", {bus32.hi, bus32.lo}, 64'h0000_0064_FFFF_FFFF);
        check("divu0_div0", 64'(bus32.div0), 64'd1);

        // MULTU after divide-by-zero: flag clears on acceptance
        run32(3'b001, 32'd3, 32'd5, -1, -1, lat, nbusy, ndone, d0);
        check("div0_clear_at_accept", 64'(d0), 64'd0);
        check("multu_small_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_0000_000F);

        // DIV MIN / -1
        run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, lat, nbusy, ndone, d0);
        check("div_min_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_8000_0000);
        check("div_min_div0", 64'(bus32.div0), 64'd0);

        // MTHI
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = 3'b100;
        bus32.a     = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b0;
        check("mthi_hi", 64'(bus32.hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(bus32.lo), 64'h8000_0000);
        check("mthi_busy0", 64'(bus32.busy), 64'd0);
        check("mthi_done_early", 64'(bus32.done), 64'd0);
        @(negedge clk);
        check("mthi_done", 64'(bus32.done), 64'd1);
        check("mthi_busy1", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        check("mthi_done_end", 64'(bus32.done), 64'd0);

        // MTLO
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = 3'b101;
        bus32.a     = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b0;
        check("mtlo_lo", 64'(bus32.lo), 64'hCAFE_F00D);
        check("mtlo_hi_kept", 64'(bus32.hi), 64'h1234_5678);
        check("mtlo_busy0", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        check("mtlo_done", 64'(bus32.done), 64'd1);

        // Reserved op: no busy, no done, registers untouched
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = 3'b110;
        bus32.a     = 32'hDEAD_BEEF;
        @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus32.start = 1'b0;
            if (bus32.done || bus32.busy) cnt++;
        end
        check("reserved_activity", 64'(cnt), 64'd0);
        check("reserved_hilo", {bus32.hi, bus32.lo}, 64'h1234_5678_CAFE_F00D);

        // DIVU 50/7 with an ignored start during busy
        run32(3'b011, 32'd50, 32'd7, 5, -1, lat, nbusy, ndone, d0);
        check("ignore_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_0000_0007);
        check("ignore_done_pulses", 64'(ndone), 64'd1);
        check("ignore_lat", 64'(lat), 64'd34);

        // MULTU aborted by reset at cycle +10, then DIVU 9/4
        run32(3'b001, 32'h0001_2345, 32'h0000_0010, -1, 10, lat, nbusy, ndone, d0);
        @(negedge clk);
        check("post_rst_busy", 64'(bus32.busy), 64'd0);
        run32(3'b011, 32'd9, 32'd4, -1, -1, lat, nbusy, ndone, d0);
        check("post_rst_divu_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_0000_0002);
        check("post_rst_divu_lat", 64'(lat), 64'd34);

        // 8-bit instance
        run8(3'b000, 8'h80, 8'h80, lat);
        check("w8_mult_lat", 64'(lat), 64'd10);
        check("w8_mult_hilo", {48'd0, bus8.hi, bus8.lo}, 64'h4000);
        run8(3'b010, 8'hF9, 8'h02, lat);
        check("w8_div_hilo", {48'd0, bus8.hi, bus8.lo}, 64'hFFFD);
        run8(3'b010, 8'h80, 8'hFF, lat);
        check("w8_div_min_hilo", {48'd0, bus8.hi, bus8.lo}, 64'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
